// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor: condition op encodings,
// 2-bit saturating counter states and the counter training step.
package branch_pkg;

  typedef enum logic [1:0] {
    BR_EQZ = 2'd0,
    BR_NEZ = 2'd1,
    BR_LTZ = 2'd2,
    BR_GEZ = 2'd3
  } br_op_e;

  localparam logic [1:0] CNT_SNT   = 2'b00;
  localparam logic [1:0] CNT_WNT   = 2'b01;
  localparam logic [1:0] CNT_WT    = 2'b10;
  localparam logic [1:0] CNT_ST    = 2'b11;
  localparam logic [1:0] CNT_RESET = CNT_WNT;

  // One training step: move toward the resolved direction, saturating at both ends.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'b01;
    else       return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: tests a register operand
// against zero or its sign bit according to the op encoding.
module branch_cond
  import branch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_val,
  input  br_op_e           i_op,
  output logic             o_taken
);

  always_comb begin
    o_taken = 1'b0;
    unique case (i_op)
      BR_EQZ: o_taken = (i_val == '0);
      BR_NEZ: o_taken = (i_val != '0);
      BR_LTZ: o_taken = i_val[WIDTH-1];
      BR_GEZ: o_taken = !i_val[WIDTH-1];
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Untagged table of 2-bit saturating counters: registered lookup for fetch,
// resolve/train from execute with registered mispredict, redirect target and stats.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid,
  input  logic [WIDTH-1:0] lk_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             rs_valid,
  input  logic [WIDTH-1:0] rs_pc,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rs_imm,
  input  logic [1:0]       rs_op,
  input  logic             rs_pred,
  output logic             mis_valid,
  output logic [WIDTH-1:0] mis_target,
  output logic [CNT_W-1:0] mis_count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]       r_table [DEPTH];
  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_rs_idx;
  logic             w_taken;
  logic             w_mispredict;
  logic [WIDTH-1:0] w_target;
  logic             w_unused;

  // PC bits above the index are deliberately dropped; aliasing is accepted.
  assign w_lk_idx = lk_pc[IDX_W-1:0];
  assign w_rs_idx = rs_pc[IDX_W-1:0];
  assign w_unused = ^lk_pc[WIDTH-1:IDX_W];

  branch_cond #(.WIDTH(WIDTH)) u_cond (
    .i_val   (rs_val),
    .i_op    (br_op_e'(rs_op)),
    .o_taken (w_taken)
  );

  assign w_mispredict = w_taken != rs_pred;
  assign w_target     = w_taken ? rs_pc + rs_imm : rs_pc + {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is reset entry by entry because the reset state (weakly
      // not-taken) is architecturally visible; this keeps it in flops, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) r_table[i] <= CNT_RESET;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      mis_valid  <= 1'b0;
      mis_target <= '0;
      mis_count  <= '0;
    end else begin
      pred_valid <= lk_valid;
      // Lookup reads the pre-update entry even when a resolve hits the same index.
      if (lk_valid) pred_taken <= r_table[w_lk_idx][1];

      mis_valid <= rs_valid && w_mispredict;
      if (rs_valid) begin
        mis_target          <= w_target;
        r_table[w_rs_idx]   <= cnt_next(r_table[w_rs_idx], w_taken);
        if (w_mispredict && (mis_count != {CNT_W{1'b1}}))
          mis_count <= mis_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed, table-driven bench for branch_predict_unit: a 64-entry/16-bit instance
// driven from a vector table, and a CNT_W=4 instance for saturation and mid-stream reset.
module tb_branch_predict_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rst4;
  logic        lk_valid;
  logic [15:0] lk_pc;
  logic        rs_valid, rs_valid4;
  logic [15:0] rs_pc, rs_val, rs_imm;
  logic [1:0]  rs_op;
  logic        rs_pred;

  logic        pred_valid, pred_taken, mis_valid;
  logic [15:0] mis_target, mis_count;
  logic        pred_valid4, pred_taken4, mis_valid4;
  logic [15:0] mis_target4;
  logic [3:0]  mis_count4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.WIDTH(16), .DEPTH(64), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .rs_valid(rs_valid), .rs_pc(rs_pc), .rs_val(rs_val), .rs_imm(rs_imm),
    .rs_op(rs_op), .rs_pred(rs_pred),
    .mis_valid(mis_valid), .mis_target(mis_target), .mis_count(mis_count)
  );

  branch_predict_unit #(.WIDTH(16), .DEPTH(64), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst4),
    .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_valid(pred_valid4), .pred_taken(pred_taken4),
    .rs_valid(rs_valid4), .rs_pc(rs_pc), .rs_val(rs_val), .rs_imm(rs_imm),
    .rs_op(rs_op), .rs_pred(rs_pred),
    .mis_valid(mis_valid4), .mis_target(mis_target4), .mis_count(mis_count4)
  );

  typedef struct packed {
    logic        lk_v;
    logic [15:0] lk_pc;
    logic        rs_v;
    logic [15:0] rs_pc;
    logic [15:0] rs_val;
    logic [15:0] rs_imm;
    logic [1:0]  op;
    logic        pred;
    logic        e_pv;
    logic        e_pt;
    logic        e_mv;
    logic [15:0] e_tgt;
    logic [15:0] e_mc;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic idle();
    lk_valid = 1'b0; lk_pc = 16'h0000;
    rs_valid = 1'b0; rs_valid4 = 1'b0;
    rs_pc = 16'h0000; rs_val = 16'h0000; rs_imm = 16'h0000;
    rs_op = 2'd0; rs_pred = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         lk_v  lk_pc     rs_v  rs_pc     rs_val    rs_imm    op    pred  pv    pt    mv    tgt       mc
    vecs[0]  = '{1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0000, 16'h0010, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0015, 16'd1};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0000, 16'h0010, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0015, 16'd2};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0000, 16'h0010, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0015, 16'd3};
    vecs[4]  = '{1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0015, 16'd3};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0000, 16'h0010, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0015, 16'd3};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0001, 16'h0010, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0006, 16'd4};
    vecs[7]  = '{1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0006, 16'd4};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0001, 16'h0010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0006, 16'd4};
    vecs[9]  = '{1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0006, 16'd4};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 16'hFFF0, 16'h0001, 16'h0020, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'd5};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 16'h0020, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'd6};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 16'h0010, 16'h8000, 16'h0004, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0014, 16'd6};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 16'h0010, 16'h8000, 16'h0004, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011, 16'd6};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 16'h0010, 16'h7FFF, 16'h0004, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011, 16'd6};
    vecs[15] = '{1'b0, 16'h0000, 1'b1, 16'h0010, 16'h7FFF, 16'h0004, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0014, 16'd6};
    vecs[16] = '{1'b0, 16'h0000, 1'b1, 16'h0010, 16'h8000, 16'h0004, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0011, 16'd7};
    vecs[17] = '{1'b1, 16'h0005, 1'b1, 16'h0005, 16'h0000, 16'h0010, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0015, 16'd8};
    vecs[18] = '{1'b1, 16'h0045, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0015, 16'd8};
    vecs[19] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0015, 16'd8};
    vecs[20] = '{1'b1, 16'hFFF0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0015, 16'd8};
    vecs[21] = '{1'b1, 16'h003F, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0015, 16'd8};

    // Reset held while a lookup and a taken resolve to idx 5 are presented.
    idle();
    rst = 1'b1; rst4 = 1'b1;
    lk_valid = 1'b1; lk_pc = 16'h0005;
    rs_valid = 1'b1; rs_pc = 16'h0005; rs_val = 16'h0000; rs_imm = 16'h0010;
    step();
    step();
    check("rst pred_valid", {15'd0, pred_valid}, 16'd0);
    check("rst pred_taken", {15'd0, pred_taken}, 16'd0);
    check("rst mis_valid",  {15'd0, mis_valid},  16'd0);
    check("rst mis_target", mis_target, 16'h0000);
    check("rst mis_count",  mis_count,  16'd0);
    idle();
    rst = 1'b0; rst4 = 1'b0;

    for (int i = 0; i < NV; i++) begin
      lk_valid = vecs[i].lk_v;  lk_pc  = vecs[i].lk_pc;
      rs_valid = vecs[i].rs_v;  rs_pc  = vecs[i].rs_pc;
      rs_val   = vecs[i].rs_val; rs_imm = vecs[i].rs_imm;
      rs_op    = vecs[i].op;    rs_pred = vecs[i].pred;
      step();
      check($sformatf("row%0d pred_valid", i), {15'd0, pred_valid}, {15'd0, vecs[i].e_pv});
      check($sformatf("row%0d pred_taken", i), {15'd0, pred_taken}, {15'd0, vecs[i].e_pt});
      check($sformatf("row%0d mis_valid", i),  {15'd0, mis_valid},  {15'd0, vecs[i].e_mv});
      check($sformatf("row%0d mis_target", i), mis_target, vecs[i].e_tgt);
      check($sformatf("row%0d mis_count", i),  mis_count,  vecs[i].e_mc);
    end
    idle();

    // Narrow statistics counter: 17 back-to-back mispredicts saturate at 15.
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      rs_valid4 = 1'b1; rs_pc = 16'h0002; rs_val = 16'h0000; rs_op = 2'd0; rs_pred = 1'b0;
      step();
      check($sformatf("sat%0d mis_valid", i), {15'd0, mis_valid4}, 16'd1);
      check($sformatf("sat%0d mis_count", i), {12'd0, mis_count4}, (i + 1 > 15) ? 16'd15 : 16'(i + 1));
    end
    rs_valid4 = 1'b0;
    step();
    check("sat hold mis_count", {12'd0, mis_count4}, 16'd15);
    check("sat hold mis_valid", {15'd0, mis_valid4}, 16'd0);

    // Reset arriving with a mispredicting resolve: no pulse, stats and table cleared.
    rst4 = 1'b1; rs_valid4 = 1'b1;
    step();
    check("midrst mis_valid", {15'd0, mis_valid4}, 16'd0);
    check("midrst mis_count", {12'd0, mis_count4}, 16'd0);
    rst4 = 1'b0; rs_valid4 = 1'b0;
    lk_valid = 1'b1; lk_pc = 16'h0002;
    step();
    check("midrst pred_valid", {15'd0, pred_valid4}, 16'd1);
    check("midrst pred_taken", {15'd0, pred_taken4}, 16'd0);
    // One taken resolve from the weakly-not-taken reset state flips the prediction.
    lk_valid = 1'b0; rs_valid4 = 1'b1;
    step();
    check("retrain mis_count", {12'd0, mis_count4}, 16'd1);
    rs_valid4 = 1'b0; lk_valid = 1'b1;
    step();
    check("retrain pred_taken", {15'd0, pred_taken4}, 16'd1);
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
